// File: rtl/regdump_pkg.sv
// Shared types for the register-file dump reader.
//   state_t        : top-level FSM states
//   BYTES_PER_REG  : bytes per register at the default 32-bit XLEN
//   bytes_per_reg  : the same figure for an arbitrary XLEN
package regdump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    CKSUM,
    FIN
  } state_t;

  localparam int XLEN_DFLT     = 32;
  localparam int BYTES_PER_REG = XLEN_DFLT / 8;

  function automatic int bytes_per_reg(input int xlen);
    return xlen / 8;
  endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Handshake and bus bundle of the register-file dump reader.
//   master : the reader. Drives busy, done, rf_addr, tx_data and tx_valid.
//            Receives start, rf_data and tx_ready.
//   slave  : the host/core side. Drives start, rf_data and tx_ready.
interface regfile_dump_reader_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rf_addr;
  logic [XLEN-1:0]   rf_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    input  start, rf_data, tx_ready,
    output busy, done, rf_addr, tx_data, tx_valid
  );

  modport slave (
    output start, rf_data, tx_ready,
    input  busy, done, rf_addr, tx_data, tx_valid
  );
endinterface

// File: rtl/regdump_byte_ser.sv
// Word-to-byte serializer.
// Loads an XLEN word and emits it least significant byte first on a valid/ready handshake.
// last is raised while the final byte is presented.
//   clk, reset : clock; synchronous active-low reset
//   load       : capture word. This takes priority over a transfer in the same cycle.
//   word       : word to serialize
//   ready      : consumer accepts data when valid && ready
//   data       : current byte (shifter[7:0])
//   valid      : a byte is pending
//   last       : the pending byte is the final byte of the word
module regdump_byte_ser #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [XLEN-1:0] word,
  input  logic            ready,
  output logic [7:0]      data,
  output logic            valid,
  output logic            last
);
  import regdump_pkg::*;

  localparam int BYTES = bytes_per_reg(XLEN);
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [XLEN-1:0]  sh;
  logic [CNT_W-1:0] byte_cnt;

  assign data = sh[7:0];
  assign last = valid && (byte_cnt == CNT_W'(BYTES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      sh       <= '0;
      byte_cnt <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      sh       <= word;
      byte_cnt <= '0;
      valid    <= 1'b1;
    end else if (valid && ready) begin
      sh <= sh >> 8;
      if (last) begin
        valid    <= 1'b0;
        byte_cnt <= '0;
      end else begin
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader.
// Walks x0..x[NUM_REGS-1] through an asynchronous read port.
// Each register is snapshotted in its LOAD cycle.
// Each value is streamed to the UART TX byte interface, least significant byte first.
//   clk   : clock
//   reset : synchronous active-low reset. It abandons a dump in progress, with no done pulse.
//   bus   : regfile_dump_reader_if.master. It carries start/busy/done, rf_addr/rf_data
//           and tx_data/tx_valid/tx_ready.
// Optional feature: define REGDUMP_CKSUM_EN to append one byte after the data bytes.
// That byte is the XOR of every data byte sent.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5
) (
  input logic clk,
  input logic reset,
  regfile_dump_reader_if.master bus
);
  import regdump_pkg::*;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              busy_q, done_q;
  logic [7:0]        ser_data;
  logic              ser_valid, ser_last, ser_load;

  // The read port is combinational, so rf_data is valid during LOAD and is captured at its edge.
  assign ser_load    = (state == LOAD);
  assign bus.rf_addr = idx;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  regdump_byte_ser #(.XLEN(XLEN)) u_ser (
    .clk   (clk),
    .reset (reset),
    .load  (ser_load),
    .word  (bus.rf_data),
    .ready (bus.tx_ready),
    .data  (ser_data),
    .valid (ser_valid),
    .last  (ser_last)
  );

`ifdef REGDUMP_CKSUM_EN
  logic [7:0] cksum;
  assign bus.tx_data  = (state == CKSUM) ? cksum : ser_data;
  assign bus.tx_valid = ser_valid || (state == CKSUM);
`else
  assign bus.tx_data  = ser_data;
  assign bus.tx_valid = ser_valid;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      idx    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef REGDUMP_CKSUM_EN
      cksum  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state  <= LOAD;
          idx    <= '0;
          busy_q <= 1'b1;
`ifdef REGDUMP_CKSUM_EN
          cksum  <= '0;
`endif
        end
        LOAD: state <= SEND;
        SEND: if (ser_valid && bus.tx_ready) begin
`ifdef REGDUMP_CKSUM_EN
          cksum <= cksum ^ ser_data;
`endif
          if (ser_last) begin
            if (idx < ADDR_W'(NUM_REGS - 1)) begin
              idx   <= idx + 1'b1;
              state <= LOAD;
            end else begin
`ifdef REGDUMP_CKSUM_EN
              state  <= CKSUM;
`else
              state  <= FIN;
              done_q <= 1'b1;
`endif
            end
          end
        end
        CKSUM: if (bus.tx_ready) begin
          state  <= FIN;
          done_q <= 1'b1;
        end
        // done is high for this single cycle; busy drops with the return to IDLE
        FIN: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: scoreboard plus randomized backpressure.
// When a dump starts, the expected byte stream is pushed into a queue.
// That stream is computed from the register model.
// A monitor pops the queue and compares on every tx transfer.
module tb_regfile_dump_reader;
  import regdump_pkg::*;

`ifdef REGDUMP_CKSUM_EN
  localparam int NB = 129;
  localparam int EXP_DONE = 162;
`else
  localparam int NB = 128;
  localparam int EXP_DONE = 161;
`endif

  logic clk, reset;
  logic [31:0] rf [32];
  regfile_dump_reader_if #(.XLEN(32), .ADDR_W(5)) bus ();

  regfile_dump_reader dut (.clk(clk), .reset(reset), .bus(bus));

  assign bus.rf_data = rf[bus.rf_addr];

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [7:0] q[$];
  logic [7:0] rx[$];
  logic [7:0] ref1[$];
  int bytes_seen, done_cnt, done_cyc, first_vld, busy_falls;
  bit rnd = 0;

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // tx_ready driver: 30% high under backpressure, otherwise always 1
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.tx_ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Monitor. It samples at negedge, mid-cycle, so values equal those seen at the next posedge.
  initial begin
    bit stall_prev, busy_prev, done_prev;
    logic [7:0] data_prev;
    stall_prev = 0; busy_prev = 0; done_prev = 0; data_prev = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (stall_prev) chk("hold_stable", {bus.tx_valid, bus.tx_data}, {1'b1, data_prev});
        if (bus.tx_valid && first_vld < 0) first_vld = cyc;
        if (bus.tx_valid && bus.tx_ready) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_byte got %0h want none", bus.tx_data);
          end else begin
            chk("byte", bus.tx_data, q.pop_front());
          end
          rx.push_back(bus.tx_data);
          bytes_seen++;
        end
        if (bus.done) begin
          if (done_prev) begin
            checks++; errors++;
            $display("FAIL done_width got 2+ cycles want 1");
          end
          done_cnt++;
          done_cyc = cyc;
          chk("done_q_empty", q.size(), 0);
        end
        if (busy_prev && !bus.busy) busy_falls++;
        stall_prev = bus.tx_valid && !bus.tx_ready;
        data_prev  = bus.tx_data;
        busy_prev  = bus.busy;
        done_prev  = bus.done;
      end else begin
        stall_prev = 0; busy_prev = 0; done_prev = 0;
      end
    end
  end

  // Reference: the whole dump is the NUM_REGS words, each sent little-endian.
  // The words are taken from the register model at the time start is issued.
  // The optional trailing byte is their XOR.
  task automatic run_dump(input int mid_start, input bit fin_start, input int rst_at,
                          input int wr5_at, output int c0);
    logic [7:0] cks;
    logic [31:0] w;
    bit ms, wr;
    cks = 0; ms = 0; wr = 0;
    for (int r = 0; r < 32; r++) begin
      w = rf[r];
      for (int b = 0; b < BYTES_PER_REG; b++) begin
        q.push_back(w[8*b +: 8]);
        cks ^= w[8*b +: 8];
      end
    end
`ifdef REGDUMP_CKSUM_EN
    q.push_back(cks);
`endif
    bytes_seen = 0; rx.delete(); first_vld = -1;
    bus.start = 1'b1; c0 = cyc;
    @(posedge clk); #1; bus.start = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (bus.done) begin
        if (fin_start) begin
          bus.start = 1'b1;
          @(posedge clk); #1; bus.start = 1'b0;
        end
        return;
      end
      if (rst_at >= 0 && bytes_seen >= rst_at) begin
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        reset = 1'b1;
        q.delete();
        return;
      end
      if (wr5_at >= 0 && !wr && bytes_seen >= wr5_at) begin rf[5] = 32'hDEADBEEF; wr = 1; end
      if (mid_start >= 0 && !ms && bytes_seen >= mid_start) begin bus.start = 1'b1; ms = 1; end
      @(posedge clk); #1; bus.start = 1'b0;
    end
    checks++; errors++;
    $display("FAIL timeout got no done want done");
  endtask

  initial begin
    int c0, d0;
    reset = 1'b0; bus.start = 1'b0;
    bytes_seen = 0; done_cnt = 0; done_cyc = 0; first_vld = -1; busy_falls = 0;
    for (int r = 0; r < 32; r++) rf[r] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_tx_valid", bus.tx_valid, 0);
    chk("reset_tx_data", bus.tx_data, 8'h00);
    chk("reset_rf_addr", bus.rf_addr, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: basic dump, tx_ready=1
    rf[1] = 32'h00000008; rf[5] = 32'h00000006; rf[9] = 32'h80000000;
    d0 = done_cnt;
    run_dump(-1, 0, -1, -1, c0);
    repeat (3) @(posedge clk); #1;
    chk("t1_done_cycle", done_cyc - c0, EXP_DONE);
    chk("t1_first_valid", first_vld - c0, 2);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_bytes", bytes_seen, NB);
    chk("t1_x1", {rx[7], rx[6], rx[5], rx[4]}, 32'h00000008);
    chk("t1_x5", {rx[23], rx[22], rx[21], rx[20]}, 32'h00000006);
    chk("t1_x9", {rx[39], rx[38], rx[37], rx[36]}, 32'h80000000);
`ifdef REGDUMP_CKSUM_EN
    chk("t6_cksum", rx[128], 8'h8E);
`endif
    ref1 = rx;

    // 2: random backpressure, same stream
    rnd = 1; d0 = done_cnt;
    run_dump(-1, 0, -1, -1, c0);
    rnd = 0;
    repeat (3) @(posedge clk); #1;
    begin
      int mm = 0;
      for (int i = 0; i < NB; i++) if (rx[i] !== ref1[i]) mm++;
      chk("t2_stream_vs_t1", {rx.size(), mm}, {NB, 32'd0});
    end
    chk("t2_done_cnt", done_cnt - d0, 1);

    // 3: start pulses at byte 50 and in the FIN cycle are ignored
    busy_falls = 0; d0 = done_cnt;
    run_dump(50, 1, -1, -1, c0);
    repeat (20) @(posedge clk); #1;
    chk("t3_bytes", bytes_seen, NB);
    chk("t3_busy_falls", busy_falls, 1);
    chk("t3_busy_idle", bus.busy, 0);
    chk("t3_done_cnt", done_cnt - d0, 1);
    chk("t3_done_cycle", done_cyc - c0, EXP_DONE);

    // 4: reset at byte 70, then a fresh full dump
    d0 = done_cnt;
    run_dump(-1, 0, 70, -1, c0);
    repeat (10) @(posedge clk); #1;
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_idle_valid", bus.tx_valid, 0);
    run_dump(-1, 0, -1, -1, c0);
    repeat (3) @(posedge clk); #1;
    chk("t4_fresh_bytes", bytes_seen, NB);
    chk("t4_fresh_done", done_cnt - d0, 1);

    // 5: x5 written mid-send; the old value is sent, and the new value is seen next dump
    run_dump(-1, 0, -1, 21, c0);
    repeat (3) @(posedge clk); #1;
    chk("t5_old_x5", {rx[23], rx[22], rx[21], rx[20]}, 32'h00000006);
    run_dump(-1, 0, -1, -1, c0);
    repeat (3) @(posedge clk); #1;
    chk("t5_new_x5", {rx[20], rx[21], rx[22], rx[23]}, 32'hEFBEADDE);
    chk("t5_bytes", bytes_seen, NB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
